// File: rtl/gpio_pad_bus_master_if.sv
// Host request/response and pad-vector signals of the pad-side bus master.
// The master modport is the RTL side; the slave modport is the host/pad side.
interface gpio_pad_bus_master_if;
    logic [15:0] io_in;
    logic [15:0] io_out;
    logic [15:0] io_oeb;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;

    modport master (
        input  io_in,
        output io_out,
        output io_oeb,
        input  req_valid,
        output req_ready,
        input  req_we,
        input  req_wdata,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

    modport slave (
        output io_in,
        input  io_out,
        input  io_oeb,
        output req_valid,
        input  req_ready,
        output req_we,
        output req_wdata,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );
endinterface

// File: rtl/gpio_pad_bus_master.sv
// Pad-side master: turns single host byte requests into a strobe/ack
// four-phase handshake on a half-duplex 8-bit pad bus, with turnaround and timeout.
module gpio_pad_bus_master #(
    parameter int unsigned TURN_CYCLES = 2,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   rst_n,
    gpio_pad_bus_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_SETUP = 3'd1,
        W_STRB  = 3'd2,
        W_HOLD  = 3'd3,
        TURN    = 3'd4,
        R_STRB  = 3'd5,
        R_HOLD  = 3'd6
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic [SYNC_STAGES-1:0][8:0]   r_sync;
    logic [7:0]                    r_cnt;
    logic [7:0]                    r_wdata;
    logic [7:0]                    r_rdata;
    logic                          r_rnw;
    logic                          r_ready_en;

    logic                          w_ack_s;
    logic [7:0]                    w_data_s;
    logic                          w_accept;
    logic                          w_tmo;
    logic                          w_turn_done;
    logic                          w_rsp_valid;
    logic                          w_rsp_err;
    logic                          w_rd_tmo;
    logic                          w_drive;
    logic                          w_strb;

    // ack and data share one synchroniser chain so data is coherent with ack
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync[0] <= {bus.io_in[10], bus.io_in[7:0]};
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_ack_s     = r_sync[SYNC_STAGES-1][8];
    assign w_data_s    = r_sync[SYNC_STAGES-1][7:0];
    assign w_accept    = (r_state == IDLE) && r_ready_en && bus.req_valid;
    assign w_tmo       = (r_cnt == 8'(TIMEOUT - 1));
    assign w_turn_done = (r_cnt == 8'(TURN_CYCLES - 1));

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timeout fires on the cycle whose increment would reach TIMEOUT, so a
    // silent device sees strb for exactly TIMEOUT cycles.
    always_comb begin
        w_next      = r_state;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rd_tmo    = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = bus.req_we ? W_SETUP : R_STRB;
                end
            end
            W_SETUP: w_next = W_STRB;
            W_STRB: begin
                if (w_ack_s) begin
                    w_next = W_HOLD;
                end else if (w_tmo) begin
                    w_next      = TURN;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end
            end
            W_HOLD: begin
                if (!w_ack_s) begin
                    w_next      = TURN;
                    w_rsp_valid = 1'b1;
                end else if (w_tmo) begin
                    w_next      = TURN;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                end
            end
            TURN: begin
                if (w_turn_done) begin
                    w_next = IDLE;
                end
            end
            R_STRB: begin
                if (w_ack_s) begin
                    w_next = R_HOLD;
                end else if (w_tmo) begin
                    w_next      = IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rd_tmo    = 1'b1;
                end
            end
            R_HOLD: begin
                if (!w_ack_s) begin
                    w_next      = IDLE;
                    w_rsp_valid = 1'b1;
                end else if (w_tmo) begin
                    w_next      = IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = 1'b1;
                    w_rd_tmo    = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_rnw      <= 1'b0;
            r_ready_en <= 1'b0;
        end else begin
            r_ready_en <= 1'b1;
            if (r_state == IDLE || w_next != r_state) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_accept) begin
                r_wdata <= bus.req_wdata;
                r_rnw   <= ~bus.req_we;
            end
            if (r_state == R_STRB && w_ack_s) begin
                r_rdata <= w_data_s;
            end else if (w_rd_tmo) begin
                r_rdata <= '0;
            end
        end
    end

    assign w_drive = (r_state == W_SETUP) || (r_state == W_STRB) || (r_state == W_HOLD);
    assign w_strb  = (r_state == W_STRB) || (r_state == R_STRB);

    always_comb begin
        bus.io_out        = '0;
        bus.io_out[7:0]   = w_drive ? r_wdata : 8'h00;
        bus.io_out[8]     = w_strb;
        bus.io_out[9]     = r_rnw;
        bus.io_oeb        = {8'hFC, (w_drive ? 8'h00 : 8'hFF)};
        bus.req_ready     = r_ready_en && (r_state == IDLE);
        bus.rsp_valid     = w_rsp_valid;
        bus.rsp_err       = w_rsp_err;
        bus.rsp_rdata     = w_rd_tmo ? 8'h00 : r_rdata;
    end

endmodule

// File: tb/tb_gpio_pad_bus_master.sv
// Scoreboard bench for gpio_pad_bus_master: directed requests push expected
// responses; a monitor pops them on rsp_valid. A device model drives ack/data.
module tb_gpio_pad_bus_master;

    localparam int unsigned TURN_CYCLES = 2;
    localparam int unsigned TIMEOUT     = 255;
    localparam int unsigned SYNC_STAGES = 2;

    localparam int DEV_NORMAL = 0;
    localparam int DEV_SILENT = 1;
    localparam int DEV_STUCK  = 2;

    typedef struct packed {
        logic       err;
        logic [7:0] rdata;
    } exp_t;

    logic clk;
    logic rst_n;
    gpio_pad_bus_master_if bus ();

    gpio_pad_bus_master #(
        .TURN_CYCLES (TURN_CYCLES),
        .TIMEOUT     (TIMEOUT),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .wb_clk_i (clk),
        .rst_n    (rst_n),
        .bus      (bus.master)
    );

    int         n_chk  = 0;
    int         n_fail = 0;
    exp_t       q[$];
    int         dev_mode = DEV_NORMAL;
    logic [7:0] cur_wdata = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Off-chip device: ack 3 cycles after strb, drop 2 cycles after strb falls.
    initial begin
        int  hi;
        int  lo;
        logic ack;
        hi = 0; lo = 0; ack = 1'b0;
        bus.io_in = 16'hFB00;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                ack = 1'b0; hi = 0; lo = 0;
            end else if (bus.io_out[8]) begin
                hi++;
                lo = 0;
                if (hi == 3 && dev_mode != DEV_SILENT) ack = 1'b1;
            end else begin
                hi = 0;
                if (ack && dev_mode != DEV_STUCK) begin
                    lo++;
                    if (lo == 2) begin
                        ack = 1'b0;
                        lo  = 0;
                    end
                end
            end
            // unused input bits held high to show they are ignored
            bus.io_in        = 16'hFB00;
            bus.io_in[10]    = ack;
            bus.io_in[7:0]   = ack ? 8'h3C : 8'h00;
        end
    end

    // Response monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.rsp_valid) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 16'(bus.rsp_valid), 16'h0);
                end else begin
                    e = q.pop_front();
                    check("rsp_err", 16'(bus.rsp_err), 16'(e.err));
                    check("rsp_rdata", 16'(bus.rsp_rdata), 16'(e.rdata));
                end
            end
        end
    end

    // Pad monitor: direction and write data consistency every cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.io_out[8] && bus.io_out[9])
                    check("rd_strb_oeb", 16'(bus.io_oeb[7:0]), 16'h00FF);
                if (bus.io_out[8] && !bus.io_out[9])
                    check("wr_strb_oeb", 16'(bus.io_oeb[7:0]), 16'h0000);
                if (bus.io_oeb[7:0] == 8'h00) begin
                    check("wr_data", 16'(bus.io_out[7:0]), 16'(cur_wdata));
                    check("wr_rnw", 16'(bus.io_out[9]), 16'h0);
                end
                check("oeb_hi", 16'(bus.io_oeb[15:8]), 16'h00FC);
            end
        end
    end

    task automatic issue(input logic we, input logic [7:0] wd, input logic push,
                         input logic exp_err, input logic [7:0] exp_rd);
        int n;
        n = 0;
        @(negedge clk);
        bus.req_we    = we;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        while (!bus.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            check("accept_timeout", 16'(bus.req_ready), 16'h1);
            bus.req_valid = 1'b0;
            return;
        end
        if (push) q.push_back('{err: exp_err, rdata: exp_rd});
        if (we) cur_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 2000);
        if (!bus.rsp_valid) check("rsp_timeout", 16'(bus.rsp_valid), 16'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 16'(q.size()), 16'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int rsp_at;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_wdata = 8'h00;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_io_out", bus.io_out, 16'h0000);
        check("rst_io_oeb", bus.io_oeb, 16'hFCFF);
        check("rst_req_ready", 16'(bus.req_ready), 16'h0);
        check("rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        check("rst_rsp_rdata", 16'(bus.rsp_rdata), 16'h0);
        check("rst_rsp_err", 16'(bus.rsp_err), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 16'(bus.req_ready), 16'h1);

        // normal write A5
        dev_mode = DEV_NORMAL;
        issue(1'b1, 8'hA5, 1'b1, 1'b0, 8'h00);
        check("wr_rnw_pin", 16'(bus.io_out[9]), 16'h0);
        wait_rsp(lat);
        @(negedge clk);
        check("wr_turn_ready0", 16'(bus.req_ready), 16'h0);
        check("wr_turn_oeb", 16'(bus.io_oeb[7:0]), 16'h00FF);
        @(negedge clk);
        check("wr_turn_ready1", 16'(bus.req_ready), 16'h0);
        @(negedge clk);
        check("wr_turn_done", 16'(bus.req_ready), 16'h1);
        drain();

        // normal read 3C
        issue(1'b0, 8'h00, 1'b1, 1'b0, 8'h3C);
        check("rd_rnw_pin", 16'(bus.io_out[9]), 16'h1);
        wait_rsp(lat);
        check("rd_latency_bound", 16'(lat >= int'(2 * SYNC_STAGES + 2) && lat <= 12), 16'h1);
        @(negedge clk);
        check("rd_ready_next", 16'(bus.req_ready), 16'h1);
        drain();

        // write with silent device: strb for TIMEOUT cycles, rdata unchanged
        dev_mode = DEV_SILENT;
        issue(1'b1, 8'h69, 1'b1, 1'b1, 8'h3C);
        n = 0;
        lat = 0;
        while (lat < 2000) begin
            @(negedge clk);
            lat++;
            if (bus.io_out[8]) n++;
            else if (n > 0) break;
        end
        check("wr_tmo_strb_cycles", 16'(n), 16'(TIMEOUT));
        check("wr_tmo_turn_oeb", 16'(bus.io_oeb[7:0]), 16'h00FF);
        check("wr_tmo_turn_ready", 16'(bus.req_ready), 16'h0);
        drain();

        // read with ack stuck high: R_HOLD timeout, rdata cleared
        dev_mode = DEV_STUCK;
        issue(1'b0, 8'h00, 1'b1, 1'b1, 8'h00);
        wait_rsp(lat);
        drain();
        dev_mode = DEV_NORMAL;
        repeat (10) @(negedge clk);

        // back-to-back write then read with req_valid held
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_wdata = 8'h5A;
        bus.req_valid = 1'b1;
        n = 0;
        while (!bus.req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cur_wdata = 8'h5A;
        q.push_back('{err: 1'b0, rdata: 8'h00});
        @(posedge clk);
        #1;
        bus.req_we = 1'b0;
        q.push_back('{err: 1'b0, rdata: 8'h3C});
        n = 0;
        rsp_at = -100;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (bus.rsp_valid) rsp_at = n;
            if (bus.req_ready) break;
        end
        check("b2b_read_after_turn", 16'(n - rsp_at), 16'(TURN_CYCLES + 1));
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        drain();

        // reset asserted during W_STRB
        dev_mode = DEV_SILENT;
        issue(1'b1, 8'h96, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (!bus.io_out[8] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("mid_rst_in_strb", 16'(bus.io_out[8]), 16'h1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_io_oeb", bus.io_oeb, 16'hFCFF);
        check("mid_rst_io_out", bus.io_out, 16'h0000);
        check("mid_rst_rsp_valid", 16'(bus.rsp_valid), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        dev_mode = DEV_NORMAL;
        @(negedge clk);
        check("mid_rst_ready", 16'(bus.req_ready), 16'h1);
        issue(1'b1, 8'hC3, 1'b1, 1'b0, 8'h00);
        wait_rsp(lat);
        drain();
        repeat (5) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/gpio_pad_bus_master.md
Name: gpio_pad_bus_master

Overview:
- Pad-side master for a half-duplex 8-bit parallel bus to an off-chip device, built inside the user project on the 16-bit packed io vector.
- Packed vector layout: bits [7:0] map to pads io[7:0]; bits [15:8] map to pads io[37:30].
- Converts single host byte requests into a strobe/ack four-phase handshake on the pads, with bus turnaround and a timeout.
- This is the pad-facing end of the io_in/io_out/io_oeb interface the wrapper exposes.

Parameters:
- TURN_CYCLES, 2: cycles data pads stay released after a write before the next request is accepted (1..15).
- TIMEOUT, 255: max cycles spent in any ack-wait state before abort (1..255).
- SYNC_STAGES, 2: flop stages on all io_in bits used (2..3).

Ports:
- wb_clk_i  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- io_in  in  16  pad inputs: [7:0] data, [10] ack, others ignored
- io_out  out  16  pad outputs: [7:0] data, [8] strb, [9] rnw, [15:10]=0
- io_oeb  out  16  pad output enables, active-low
- req_valid  in  1  host request
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_wdata  in  8  write byte
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  8  read byte, valid with rsp_valid on reads
- rsp_err  out  1  timeout flag, valid with rsp_valid

Behaviour:
Reset and pad enables:
- Reset values:
  - io_out=16'h0000
  - io_oeb=16'hFCFF
  - req_ready=0 during reset, 1 in the first cycle after release
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - FSM in IDLE, counters cleared
- Reset is asynchronous: mid-transaction reset releases data pads and drops strb immediately. No response is produced.
- io_oeb[15:8] is constant 8'hFC: bits 8 and 9 driven, all others input.
- io_oeb[7:0] is 8'h00 only in W_SETUP, W_STRB and W_HOLD; otherwise 8'hFF.

Input synchronisation:
- io_in[7:0] and io_in[10] pass through SYNC_STAGES flops, giving ack_s and data_s.
- Data and ack share the same delay, so data_s is coherent with ack_s rising.

FSM states:
- IDLE:
  - req_ready=1.
  - On accept, latch req_we into rnw: io_out[9] = ~we, held until the next accept.
  - Latch wdata.
  - Go to W_SETUP if write, R_STRB if read.
- W_SETUP: drive latched byte on io_out[7:0]; strb=0; exactly 1 cycle, then W_STRB.
- W_STRB:
  - strb=1, data driven.
  - On ack_s=1, go to W_HOLD.
- W_HOLD:
  - strb=0, data still driven.
  - On ack_s=0, go to TURN and pulse rsp_valid with err=0.
- TURN: data released; stay exactly TURN_CYCLES cycles, then IDLE.
- R_STRB:
  - strb=1, data pads released.
  - On the first cycle ack_s=1, capture data_s into rsp_rdata, then go to R_HOLD.
- R_HOLD:
  - strb=0.
  - On ack_s=0, pulse rsp_valid with err=0 and go to IDLE.

Timeout:
- An 8-bit wait counter clears on entry to W_STRB, W_HOLD, R_STRB and R_HOLD, and increments each cycle the exit condition is false.
- When the counter reaches TIMEOUT:
  - drop strb
  - pulse rsp_valid with rsp_err=1
  - rsp_rdata is unchanged on a write; on a read it is set to 8'h00
  - go to TURN from a write state, or to IDLE from a read state

Latency and handshake:
- rsp_valid is high exactly 1 cycle per accepted request.
- req_ready=0 from accept until IDLE is re-entered.
- A new request may be accepted in the cycle after rsp_valid for reads, and after TURN for writes.
- An ack already high at accept is treated as a stale level: the FSM still requires it observed high in the strobe state. Correct device behaviour makes this impossible; the bench covers it only via timeout.
- Ack pulses in IDLE or TURN are ignored.
- Invalid input bits [15:11], [9:8] are never sampled.

Test Plan:
- Write 8'hA5, device raises ack 3 cycles after strb and drops it 2 cycles after strb falls:
  - io_oeb[7:0]=00 from W_SETUP through W_HOLD, io_out[7:0]=A5, io_out[9]=0
  - one rsp_valid with err=0
  - req_ready low until TURN_CYCLES=2 cycles after release
- Read, device presents 8'h3C with ack:
  - io_oeb[7:0]=FF throughout, io_out[9]=1
  - rsp_rdata=3C with rsp_valid, err=0
  - total latency = handshake + 2*SYNC_STAGES bounded
- Device never acks a write:
  - strb high for exactly 255 cycles, then rsp_valid with err=1
  - data pads released after TURN, next request accepted
- Read with ack stuck high after strb falls: R_HOLD timeout gives rsp_err=1, rsp_rdata=00.
- Back-to-back write then read with req_valid held high: read accepted only after TURN; data pads never driven while strb is high on the read.
- rst_n asserted during W_STRB:
  - same cycle, io_oeb=FCFF and io_out=0000
  - no rsp_valid
  - after release, a fresh write completes normally
